abr_prim_fifo_sync_lvl: RTL and testbench

- Parametrised single-clock FIFO with occupancy level output, programmable-by-parameter almost-full and almost-empty thresholds, optional fall-through mode, and sticky overflow/underflow error flags.
- Pointer and level widths are sized with abr_prim_util_pkg::vbits, so Depth=1 is fully legal.
- Used as the standard buffering primitive between Adams Bridge datapath stages, for example between the sampler and NTT front-end.

---
 rtl/abr_prim_util_pkg.sv | 33 +++
 rtl/abr_prim_fifo_sync_lvl_assert.sv | 34 +++
 rtl/abr_prim_fifo_sync_lvl_ctrl.sv | 161 ++++++++++++++++
 rtl/abr_prim_fifo_sync_lvl.sv | 102 ++++++++++
 tb/tb_abr_prim_fifo_sync_lvl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/abr_prim_util_pkg.sv
// Shared sizing and pointer helpers for the Adams Bridge primitive library.
//   vbits(v)          : bits needed to index v distinct values, never less than 1
//   fifo_ptr_w(depth) : FIFO read/write pointer width
//   fifo_lvl_w(depth) : FIFO occupancy width, able to hold 0..depth
//   ptr_inc(ptr,depth): pointer increment that wraps from depth-1 to 0 for any depth
package abr_prim_util_pkg;

  function automatic int vbits(input int value);
    if (value <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(value);
    end
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return vbits(depth);
  endfunction

  function automatic int fifo_lvl_w(input int depth);
    return vbits(depth + 32'sd1);
  endfunction

  // The wrap is explicit so that non-power-of-2 depths never address past the last entry.
  function automatic int ptr_inc(input int ptr, input int depth);
    if (ptr >= depth - 32'sd1) begin
      return 32'sd0;
    end else begin
      return ptr + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/abr_prim_fifo_sync_lvl_assert.sv
// Property checker for abr_prim_fifo_sync_lvl. Properties are compiled in only
// when ABR_INC_ASSERT is defined.
// Ports: clk_i, rst_i, level_i (occupancy), rvalid_i / rdata_i (read side).
module abr_prim_fifo_sync_lvl_assert
  import abr_prim_util_pkg::*;
#(
  parameter int Width         = 32,
  parameter int Depth         = 4,
  parameter int AlmostFullTh  = Depth - 1,
  parameter int AlmostEmptyTh = 1,
  localparam int LvlW         = fifo_lvl_w(Depth)
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic [LvlW-1:0]  level_i,
  input logic             rvalid_i,
  input logic [Width-1:0] rdata_i
);

`ifdef ABR_INC_ASSERT
  level_le_depth_a: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(level_i) <= Depth);

  params_legal_a: assert property (@(posedge clk_i)
    (Depth >= 1) && (AlmostFullTh <= Depth) && (AlmostEmptyTh <= Depth));

  rdata_known_a: assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_i |-> !$isunknown(rdata_i));
`else
  logic unused_s;
  assign unused_s = ^{clk_i, rst_i, level_i, rvalid_i, rdata_i};
`endif

endmodule

// File: rtl/abr_prim_fifo_sync_lvl_ctrl.sv
// Control half of the synchronous level FIFO: pointers, occupancy level,
// registered status flags and sticky error flags. The storage array lives in the parent.
// Ports:
//   clk_i, rst_i (sync, active high), clr_i (sync flush, errors kept)
//   wvalid_i / wready_o      : write handshake
//   rvalid_o / rready_i      : read handshake (rvalid_o includes the fall-through bypass)
//   bypass_o                 : head is taken straight from the write port this cycle
//   head_valid_o             : storage holds at least one entry (registered)
//   we_o, waddr_o, raddr_o   : storage write enable and addresses
//   level_o, full_o, almost_full_o, almost_empty_o : registered occupancy status
//   err_ovf_o, err_udf_o     : sticky overflow / underflow
module abr_prim_fifo_sync_lvl_ctrl
  import abr_prim_util_pkg::*;
#(
  parameter int Depth         = 4,
  parameter bit FallThrough   = 1'b0,
  parameter int AlmostFullTh  = Depth - 1,
  parameter int AlmostEmptyTh = 1,
  localparam int PtrW         = fifo_ptr_w(Depth),
  localparam int LvlW         = fifo_lvl_w(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic            rvalid_o,
  input  logic            rready_i,
  output logic            bypass_o,
  output logic            head_valid_o,
  output logic            we_o,
  output logic [PtrW-1:0] waddr_o,
  output logic [PtrW-1:0] raddr_o,
  output logic [LvlW-1:0] level_o,
  output logic            full_o,
  output logic            almost_full_o,
  output logic            almost_empty_o,
  output logic            err_ovf_o,
  output logic            err_udf_o
);

  localparam logic AfRst = (AlmostFullTh == 0) ? 1'b1 : 1'b0;

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            head_valid_q, head_valid_d;
  logic            full_q, full_d;
  logic            af_q, af_d;
  logic            ae_q, ae_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic bypass_s, rvalid_s, wready_s, write_s, read_s, store_wr_s, mem_rd_s;

  // With Depth=1 the only legal address is 0, so the pointer never moves.
  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    if (Depth == 1) begin
      return {PtrW{1'b0}};
    end else begin
      return PtrW'(ptr_inc(int'(ptr), Depth));
    end
  endfunction

  // Handshake decode: bypass detection, accepted write/read, storage-side effects.
  always_comb begin
    bypass_s   = 1'b0;
    wready_s   = 1'b0;
    if (FallThrough) begin
      bypass_s = !head_valid_q && wvalid_i;
    end else begin
      bypass_s = 1'b0;
    end
    rvalid_s = head_valid_q || bypass_s;
    if (FallThrough && full_q) begin
      wready_s = rready_i;
    end else begin
      wready_s = !full_q;
    end
    // A write into a full FIFO is still taken when the head leaves in the same
    // cycle; the level is then unchanged and the new word queues behind the rest.
    write_s    = wvalid_i && (!full_q || (rready_i && head_valid_q));
    read_s     = rvalid_s && rready_i;
    // A bypassed word is consumed straight from the write port and never stored.
    store_wr_s = write_s && !(bypass_s && rready_i);
    mem_rd_s   = read_s && !bypass_s;
  end

  // Next-state for pointers, level, error flags and the level-derived status.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q || (wvalid_i && !write_s);
    udf_d   = udf_q || (rready_i && !rvalid_s);
    if (clr_i) begin
      wptr_d  = {PtrW{1'b0}};
      rptr_d  = {PtrW{1'b0}};
      level_d = {LvlW{1'b0}};
    end else begin
      if (store_wr_s) begin
        wptr_d = ptr_next(wptr_q);
      end else begin
        wptr_d = wptr_q;
      end
      if (mem_rd_s) begin
        rptr_d = ptr_next(rptr_q);
      end else begin
        rptr_d = rptr_q;
      end
      case ({store_wr_s, mem_rd_s})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
    head_valid_d = (level_d != {LvlW{1'b0}});
    full_d       = (int'(level_d) == Depth);
    af_d         = (int'(level_d) >= AlmostFullTh);
    ae_d         = (int'(level_d) <= AlmostEmptyTh);
  end

  // State registers with synchronous reset; errors are cleared only here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q       <= {PtrW{1'b0}};
      rptr_q       <= {PtrW{1'b0}};
      level_q      <= {LvlW{1'b0}};
      head_valid_q <= 1'b0;
      full_q       <= 1'b0;
      af_q         <= AfRst;
      ae_q         <= 1'b1;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      head_valid_q <= head_valid_d;
      full_q       <= full_d;
      af_q         <= af_d;
      ae_q         <= ae_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  assign wready_o       = wready_s;
  assign rvalid_o       = rvalid_s;
  assign bypass_o       = bypass_s;
  assign head_valid_o   = head_valid_q;
  assign we_o           = store_wr_s && !clr_i && !rst_i;
  assign waddr_o        = wptr_q;
  assign raddr_o        = rptr_q;
  assign level_o        = level_q;
  assign full_o         = full_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign err_ovf_o      = ovf_q;
  assign err_udf_o      = udf_q;

endmodule

// File: rtl/abr_prim_fifo_sync_lvl.sv
// Single-clock FIFO with occupancy level, almost-full/almost-empty thresholds,
// optional fall-through head and sticky overflow/underflow flags.
// Ports:
//   clk_i, rst_i (sync, active high), clr_i (sync flush, errors kept)
//   wvalid_i, wready_o, wdata_i : write side
//   rvalid_o, rready_i, rdata_o : read side, rdata_o is 0 whenever rvalid_o is low
//   level_o, full_o, almost_full_o, almost_empty_o : occupancy status
//   err_ovf_o, err_udf_o        : sticky error flags, cleared only by rst_i
module abr_prim_fifo_sync_lvl
  import abr_prim_util_pkg::*;
#(
  parameter int Width         = 32,
  parameter int Depth         = 4,
  parameter bit FallThrough   = 1'b0,
  parameter int AlmostFullTh  = Depth - 1,
  parameter int AlmostEmptyTh = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  input  logic [Width-1:0]              wdata_i,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [Width-1:0]              rdata_o,
  output logic [fifo_lvl_w(Depth)-1:0]  level_o,
  output logic                          full_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o,
  output logic                          err_ovf_o,
  output logic                          err_udf_o
);

  localparam int PtrW = fifo_ptr_w(Depth);
  // Storage is sized to the full pointer range so every pointer value indexes
  // a real element; entries at Depth and above are never written.
  localparam int MemDepth = 2 ** PtrW;

  logic [Width-1:0] mem_q [MemDepth];
  logic             we_s, bypass_s, head_valid_s;
  logic [PtrW-1:0]  waddr_s, raddr_s;

  abr_prim_fifo_sync_lvl_ctrl #(
    .Depth         (Depth),
    .FallThrough   (FallThrough),
    .AlmostFullTh  (AlmostFullTh),
    .AlmostEmptyTh (AlmostEmptyTh)
  ) u_ctrl (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr_i),
    .wvalid_i       (wvalid_i),
    .wready_o       (wready_o),
    .rvalid_o       (rvalid_o),
    .rready_i       (rready_i),
    .bypass_o       (bypass_s),
    .head_valid_o   (head_valid_s),
    .we_o           (we_s),
    .waddr_o        (waddr_s),
    .raddr_o        (raddr_s),
    .level_o        (level_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .err_ovf_o      (err_ovf_o),
    .err_udf_o      (err_udf_o)
  );

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_i;
    end
  end

  // Head select: write port when bypassing, stored head otherwise, zero when empty.
  always_comb begin
    rdata_o = {Width{1'b0}};
    if (bypass_s) begin
      rdata_o = wdata_i;
    end else if (head_valid_s) begin
      rdata_o = mem_q[raddr_s];
    end else begin
      rdata_o = {Width{1'b0}};
    end
  end

  abr_prim_fifo_sync_lvl_assert #(
    .Width         (Width),
    .Depth         (Depth),
    .AlmostFullTh  (AlmostFullTh),
    .AlmostEmptyTh (AlmostEmptyTh)
  ) u_assert (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .level_i  (level_o),
    .rvalid_i (rvalid_o),
    .rdata_i  (rdata_o)
  );

endmodule

// File: tb/tb_abr_prim_fifo_sync_lvl.sv
// Directed bench for abr_prim_fifo_sync_lvl. Four instances share clock and reset:
//   a: Width 8, Depth 4, registered          (table-driven vectors)
//   b: Width 8, Depth 3, registered          (wrap of a non-power-of-2 depth)
//   c: Width 8, Depth 1, fall-through        (bypass and single-entry behaviour)
//   d: Width 8, Depth 8, AF 6, AE 2          (threshold flags)
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_abr_prim_fifo_sync_lvl;

  logic clk, rst;

  logic       a_clr, a_wv, a_wready, a_rvalid, a_rr, a_full, a_af, a_ae, a_ovf, a_udf;
  logic [7:0] a_wd, a_rdata;
  logic [2:0] a_level;
  logic       b_clr, b_wv, b_wready, b_rvalid, b_rr, b_full, b_af, b_ae, b_ovf, b_udf;
  logic [7:0] b_wd, b_rdata;
  logic [1:0] b_level;
  logic       c_clr, c_wv, c_wready, c_rvalid, c_rr, c_full, c_af, c_ae, c_ovf, c_udf;
  logic [7:0] c_wd, c_rdata;
  logic [0:0] c_level;
  logic       d_clr, d_wv, d_wready, d_rvalid, d_rr, d_full, d_af, d_ae, d_ovf, d_udf;
  logic [7:0] d_wd, d_rdata;
  logic [3:0] d_level;

  int n_vec = 0;
  int n_bad = 0;

  abr_prim_fifo_sync_lvl #(.Width(8), .Depth(4), .FallThrough(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .clr_i(a_clr), .wvalid_i(a_wv), .wready_o(a_wready),
    .wdata_i(a_wd), .rvalid_o(a_rvalid), .rready_i(a_rr), .rdata_o(a_rdata),
    .level_o(a_level), .full_o(a_full), .almost_full_o(a_af), .almost_empty_o(a_ae),
    .err_ovf_o(a_ovf), .err_udf_o(a_udf));

  abr_prim_fifo_sync_lvl #(.Width(8), .Depth(3), .FallThrough(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .clr_i(b_clr), .wvalid_i(b_wv), .wready_o(b_wready),
    .wdata_i(b_wd), .rvalid_o(b_rvalid), .rready_i(b_rr), .rdata_o(b_rdata),
    .level_o(b_level), .full_o(b_full), .almost_full_o(b_af), .almost_empty_o(b_ae),
    .err_ovf_o(b_ovf), .err_udf_o(b_udf));

  abr_prim_fifo_sync_lvl #(.Width(8), .Depth(1), .FallThrough(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst), .clr_i(c_clr), .wvalid_i(c_wv), .wready_o(c_wready),
    .wdata_i(c_wd), .rvalid_o(c_rvalid), .rready_i(c_rr), .rdata_o(c_rdata),
    .level_o(c_level), .full_o(c_full), .almost_full_o(c_af), .almost_empty_o(c_ae),
    .err_ovf_o(c_ovf), .err_udf_o(c_udf));

  abr_prim_fifo_sync_lvl #(.Width(8), .Depth(8), .FallThrough(1'b0),
                           .AlmostFullTh(6), .AlmostEmptyTh(2)) u_d (
    .clk_i(clk), .rst_i(rst), .clr_i(d_clr), .wvalid_i(d_wv), .wready_o(d_wready),
    .wdata_i(d_wd), .rvalid_o(d_rvalid), .rready_i(d_rr), .rdata_o(d_rdata),
    .level_o(d_level), .full_o(d_full), .almost_full_o(d_af), .almost_empty_o(d_ae),
    .err_ovf_o(d_ovf), .err_udf_o(d_udf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector for instance a: inputs for one cycle plus the outputs expected
  // before the edge. exp_st = {wready, rvalid, level[2:0], full, af, ae, ovf, udf}.
  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       clr;
    logic [9:0] exp_st;
    logic       chk_rd;
    logic [7:0] exp_rd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr,
                              input logic clr, input logic wrdy, input logic rv,
                              input logic [2:0] lvl, input logic fu, input logic af,
                              input logic ae, input logic ov, input logic ud,
                              input logic crd, input logic [7:0] rd);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr; v.clr = clr;
    v.exp_st = {wrdy, rv, lvl, fu, af, ae, ov, ud};
    v.chk_rd = crd; v.exp_rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q3 [$];

  initial begin
    //                 wv    wd    rr    clr   wrdy  rv    lvl  full  af    ae    ovf   udf   crd   rdata
    vecs[0]  = mk(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,8'h00);
    vecs[1]  = mk(1'b1,8'h11,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h00);
    vecs[2]  = mk(1'b1,8'h22,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,8'h11);
    vecs[3]  = mk(1'b1,8'h33,1'b0,1'b0, 1'b1,1'b1,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'h11);
    vecs[4]  = mk(1'b1,8'h44,1'b0,1'b0, 1'b1,1'b1,3'd3,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,8'h11);
    vecs[5]  = mk(1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,3'd4,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,8'h11);
    vecs[6]  = mk(1'b1,8'h66,1'b1,1'b0, 1'b0,1'b1,3'd4,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,8'h11);
    vecs[7]  = mk(1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,3'd4,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,8'h22);
    vecs[8]  = mk(1'b1,8'h55,1'b0,1'b0, 1'b0,1'b1,3'd4,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,8'h22);
    vecs[9]  = mk(1'b0,8'h00,1'b1,1'b0, 1'b0,1'b1,3'd4,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,8'h22);
    vecs[10] = mk(1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,3'd3,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,8'h33);
    vecs[11] = mk(1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,3'd2,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,8'h44);
    vecs[12] = mk(1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,3'd1,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,8'h66);
    vecs[13] = mk(1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,8'h00);
    vecs[14] = mk(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,8'h00);
    vecs[15] = mk(1'b1,8'h77,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,8'h00);
    vecs[16] = mk(1'b1,8'h88,1'b0,1'b1, 1'b1,1'b1,3'd1,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1,8'h77);
    vecs[17] = mk(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,8'h00);

    rst = 1'b1;
    a_clr = 1'b0; a_wv = 1'b0; a_wd = 8'h00; a_rr = 1'b0;
    b_clr = 1'b0; b_wv = 1'b0; b_wd = 8'h00; b_rr = 1'b0;
    c_clr = 1'b0; c_wv = 1'b0; c_wd = 8'h00; c_rr = 1'b0;
    d_clr = 1'b0; d_wv = 1'b0; d_wd = 8'h00; d_rr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Depth 4: fill, full with concurrent read+write, overflow, drain, underflow, clear.
    for (int i = 0; i < NV; i++) begin
      a_wv = vecs[i].wv; a_wd = vecs[i].wd; a_rr = vecs[i].rr; a_clr = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("a_v%0d_status", i),
          32'({a_wready, a_rvalid, a_level, a_full, a_af, a_ae, a_ovf, a_udf}),
          32'(vecs[i].exp_st));
      if (vecs[i].chk_rd) begin
        chk($sformatf("a_v%0d_rdata", i), 32'(a_rdata), 32'(vecs[i].exp_rd));
      end
      next_cycle();
    end
    a_wv = 1'b0; a_rr = 1'b0; a_clr = 1'b0;

    // Reset clears the sticky flags that clr_i left alone.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("a_rst_errs", 32'({a_ovf, a_udf}), 32'(2'b00));
    chk("a_rst_state", 32'({a_level, a_rvalid, a_rdata}), 32'(12'h000));
    next_cycle();

    // Depth 3: prefill two, then ten simultaneous write/read pairs, then drain.
    for (int k = 0; k < 14; k++) begin
      b_wv = (k < 12);
      b_wd = 8'(k + 1);
      b_rr = (k >= 2);
      @(negedge clk);
      chk($sformatf("b_level_%0d", k), 32'(b_level), 32'(q3.size()));
      if (q3.size() > 0) begin
        chk($sformatf("b_rdata_%0d", k), 32'(b_rdata), 32'(q3[0]));
      end
      if (b_rr && (q3.size() > 0)) begin
        void'(q3.pop_front());
      end
      if (b_wv) begin
        q3.push_back(b_wd);
      end
      next_cycle();
    end
    b_wv = 1'b0; b_rr = 1'b0;
    @(negedge clk);
    chk("b_final", 32'({b_level, b_rvalid, b_ovf, b_udf}), 32'(5'b00000));
    next_cycle();

    // Depth 1 fall-through: bypass, single-entry full behaviour.
    @(negedge clk);
    chk("c_reset", 32'({c_wready, c_rvalid, c_level, c_full, c_af, c_ae}), 32'(6'b100011));
    next_cycle();
    c_wv = 1'b1; c_wd = 8'hA5; c_rr = 1'b1;
    @(negedge clk);
    chk("c_bypass_rv", 32'({c_rvalid, c_rdata}), 32'(9'h1A5));
    next_cycle();
    c_wv = 1'b0; c_rr = 1'b0;
    @(negedge clk);
    chk("c_bypass_after", 32'({c_level, c_rvalid, c_ovf, c_udf}), 32'(4'b0000));
    next_cycle();
    c_wv = 1'b1; c_wd = 8'h3C;
    @(negedge clk);
    chk("c_ft_write", 32'({c_rvalid, c_rdata}), 32'(9'h13C));
    next_cycle();
    c_wv = 1'b0;
    @(negedge clk);
    chk("c_full", 32'({c_level, c_full, c_wready, c_rvalid, c_af, c_ae}), 32'(6'b110111));
    chk("c_full_rdata", 32'(c_rdata), 32'(8'h3C));
    next_cycle();
    c_wv = 1'b1; c_wd = 8'h5A; c_rr = 1'b1;
    @(negedge clk);
    chk("c_full_wready", 32'({c_wready, c_rdata}), 32'(9'h13C));
    next_cycle();
    c_wv = 1'b0; c_rr = 1'b1;
    @(negedge clk);
    chk("c_swap", 32'({c_level, c_rdata}), 32'(9'h15A));
    next_cycle();
    c_rr = 1'b0;
    @(negedge clk);
    chk("c_drained", 32'({c_level, c_rvalid, c_ovf, c_udf}), 32'(4'b0000));
    next_cycle();

    // Depth 8 thresholds: fill to 6, then drain to 2.
    for (int k = 0; k < 6; k++) begin
      d_wv = 1'b1; d_wd = 8'(16 + k);
      @(negedge clk);
      chk($sformatf("d_fill_%0d", k), 32'({d_level, d_af, d_ae}),
          32'({4'(k), (k >= 6) ? 1'b1 : 1'b0, (k <= 2) ? 1'b1 : 1'b0}));
      next_cycle();
    end
    d_wv = 1'b0;
    @(negedge clk);
    chk("d_af_at6", 32'({d_level, d_af, d_ae}), 32'(6'b0110_10));
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      d_rr = 1'b1;
      @(negedge clk);
      chk($sformatf("d_drain_%0d", k), 32'({d_level, d_af, d_ae, d_rdata}),
          32'({4'(6 - k), (k == 0) ? 1'b1 : 1'b0, ((6 - k) <= 2) ? 1'b1 : 1'b0, 8'(16 + k)}));
      next_cycle();
    end
    d_rr = 1'b0;
    @(negedge clk);
    chk("d_ae_at2", 32'({d_level, d_af, d_ae, d_rdata}), 32'({4'd2, 1'b0, 1'b1, 8'h14}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
